ddr4_bank_responder: RTL and testbench

Device-side DDR4 command responder: the memory end of the command bus driven by the bank-group controllers. Decodes chip-select/RAS/CAS/WE commands per bank group and bank, tracks open rows and ACT-to-column delay per bank, stores write data in an internal array, and returns read data after a fixed CAS latency through a pipeline. Serves as the bus-functional memory that controller instances are verified against.

---
 rtl/ddr4_bank_responder_if.sv | 43 ++++
 rtl/ddr4_bank_responder.sv | 219 +++++++++++++++++++++
 tb/tb_ddr4_bank_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr4_bank_responder_if.sv
// ----------------------------------------------------------------------------
// ddr4_bank_responder_if
//
// Bundles the DDR4 command/data bus between a bank-group controller and the
// device-side responder.
//
//   ddr4_cs_n/ras_n/cas_n/we_n : command strobes, active low (controller -> device)
//   ddr4_addr[15:0]            : row address on ACT, column address on READ/WRITE
//   ddr4_ba[2:0], ddr4_bg[1:0] : bank address and bank group
//   ddr4_dq_in[15:0]           : write data, valid in the WRITE command cycle
//   ddr4_dq_out[15:0]          : read data (device -> controller)
//   dq_valid                   : ddr4_dq_out carries a read word this cycle
//   bank_open[31:0]            : per-bank open-row flag, indexed {bg,ba}
//   cmd_err                    : one-cycle pulse for a rejected command
//
// Modports: master = controller side, slave = responder side.
// ----------------------------------------------------------------------------
interface ddr4_bank_responder_if;
  logic        ddr4_cs_n;
  logic        ddr4_ras_n;
  logic        ddr4_cas_n;
  logic        ddr4_we_n;
  logic [15:0] ddr4_addr;
  logic [2:0]  ddr4_ba;
  logic [1:0]  ddr4_bg;
  logic [15:0] ddr4_dq_in;
  logic [15:0] ddr4_dq_out;
  logic        dq_valid;
  logic [31:0] bank_open;
  logic        cmd_err;

  modport master (
    output ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n,
    output ddr4_addr, ddr4_ba, ddr4_bg, ddr4_dq_in,
    input  ddr4_dq_out, dq_valid, bank_open, cmd_err
  );

  modport slave (
    input  ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n,
    input  ddr4_addr, ddr4_ba, ddr4_bg, ddr4_dq_in,
    output ddr4_dq_out, dq_valid, bank_open, cmd_err
  );
endinterface

// File: rtl/ddr4_bank_responder.sv
// ----------------------------------------------------------------------------
// ddr4_bank_responder
//
// Device-side DDR4 command responder used as the bus-functional memory for
// controller verification. Decodes ACT/READ/WRITE/PRE per bank ({bg,ba}, 32
// banks), tracks the open row and the ACT-to-column delay of every bank,
// stores write data in an internal array and returns read data CL cycles
// after the READ command through a valid/data pipeline.
//
// Parameters:
//   CL       : read latency, READ command cycle to dq_valid (1..8)
//   TRCD     : minimum cycles from ACT to READ/WRITE on a bank (1..7)
//   ROW_BITS : stored row bits, ddr4_addr[ROW_BITS-1:0]
//   COL_BITS : stored column bits, ddr4_addr[COL_BITS-1:0]
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ddr4_bank_responder_if.slave (command in, read data / status out)
// ----------------------------------------------------------------------------
module ddr4_bank_responder #(
  parameter int CL       = 3,
  parameter int TRCD     = 2,
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ddr4_bank_responder_if.slave   bus
);

  localparam int NBANK  = 32;
  localparam int ADDR_W = 5 + ROW_BITS + COL_BITS;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_READ,
    CMD_WRITE,
    CMD_PRE
  } cmd_t;

  typedef enum logic {
    BANK_IDLE,
    BANK_ACTIVE
  } bank_t;

  // Per-bank state
  bank_t                r_bank_st [NBANK];
  logic [ROW_BITS-1:0]  r_row     [NBANK];
  logic [2:0]           r_trcd    [NBANK];
  bank_t                w_bank_st_nxt [NBANK];
  logic [2:0]           w_trcd_nxt    [NBANK];

  // Command decode
  cmd_t                 w_cmd;
  logic [4:0]           w_bank;
  logic [ROW_BITS-1:0]  w_row_in;
  logic [COL_BITS-1:0]  w_col;
  logic                 w_col_ok;
  logic                 w_err;
  logic                 w_row_ld;
  logic                 w_wr_en;
  logic                 w_rd_push;
  logic [ADDR_W-1:0]    w_mem_addr;
  logic [15:0]          w_rd_data;
  logic                 w_addr_unused;

  // Storage and outputs
  logic [15:0]          r_mem [DEPTH];
  logic                 r_cmd_err;
  logic [CL-1:0]        r_vld;
  logic [CL:0]          w_vld_chain;
  wire logic [CL-1:0][15:0] w_stage_dat;
  logic [15:0]          w_dq_out;
  logic [31:0]          w_bank_open;

  assign w_bank   = {bus.ddr4_bg, bus.ddr4_ba};
  assign w_row_in = bus.ddr4_addr[ROW_BITS-1:0];
  assign w_col    = bus.ddr4_addr[COL_BITS-1:0];
  // Address bits above the stored row/column widths are don't-care.
  assign w_addr_unused = ^bus.ddr4_addr;

  always_comb begin
    w_cmd = CMD_NOP;
    if (!bus.ddr4_cs_n) begin
      case ({bus.ddr4_ras_n, bus.ddr4_cas_n, bus.ddr4_we_n})
        3'b011:  w_cmd = CMD_ACT;
        3'b101:  w_cmd = CMD_READ;
        3'b100:  w_cmd = CMD_WRITE;
        3'b010:  w_cmd = CMD_PRE;
        // NOP, REF and MRS all leave the banks untouched without error.
        default: w_cmd = CMD_NOP;
      endcase
    end
  end

  // A column access needs an open row whose tRCD window has fully elapsed.
  assign w_col_ok = (r_bank_st[w_bank] == BANK_ACTIVE) && (r_trcd[w_bank] == 3'd0);

  always_comb begin
    w_err     = 1'b0;
    w_row_ld  = 1'b0;
    w_wr_en   = 1'b0;
    w_rd_push = 1'b0;
    case (w_cmd)
      CMD_ACT: begin
        if (r_bank_st[w_bank] == BANK_ACTIVE) w_err    = 1'b1;
        else                                  w_row_ld = 1'b1;
      end
      CMD_READ: begin
        if (w_col_ok) w_rd_push = 1'b1;
        else          w_err     = 1'b1;
      end
      CMD_WRITE: begin
        if (w_col_ok) w_wr_en = 1'b1;
        else          w_err   = 1'b1;
      end
      default: ;
    endcase
  end

  // Bank next state: counters saturate at zero; an ACT reloads TRCD-1 so the
  // first legal column command lands exactly TRCD edges after the ACT.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      w_bank_st_nxt[b] = r_bank_st[b];
      w_trcd_nxt[b]    = (r_trcd[b] != 3'd0) ? (r_trcd[b] - 3'd1) : 3'd0;
    end
    if (w_row_ld) begin
      w_bank_st_nxt[w_bank] = BANK_ACTIVE;
      w_trcd_nxt[w_bank]    = 3'(TRCD - 1);
    end
    if (w_cmd == CMD_PRE) begin
      w_bank_st_nxt[w_bank] = BANK_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBANK; b++) begin
        r_bank_st[b] <= BANK_IDLE;
        r_trcd[b]    <= 3'd0;
      end
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        r_bank_st[b] <= w_bank_st_nxt[b];
        r_trcd[b]    <= w_trcd_nxt[b];
      end
    end
  end

  // Open-row register is only meaningful while the bank is ACTIVE.
  always_ff @(posedge clk) begin
    if (w_row_ld) r_row[w_bank] <= w_row_in;
  end

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      w_bank_open[b] = (r_bank_st[b] == BANK_ACTIVE);
    end
  end

  // Memory array, deliberately not cleared by reset.
  assign w_mem_addr = {w_bank, r_row[w_bank], w_col};
  assign w_rd_data  = r_mem[w_mem_addr];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_mem_addr] <= bus.ddr4_dq_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cmd_err <= 1'b0;
    else        r_cmd_err <= w_err;
  end

  // ---- read pipeline: stage 0 loads on the READ edge, stage CL-1 is the output
  assign w_vld_chain = {r_vld, w_rd_push};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld <= '0;
    else        r_vld <= w_vld_chain[CL-1:0];
  end

  for (genvar k = 0; k < CL; k++) begin : g_pipe
    logic [15:0]      r_dat;
    wire logic [15:0] w_din;

    if (k == 0) begin : g_first
      assign w_din = w_rd_data;
    end else begin : g_next
      assign w_din = w_stage_dat[k-1];
    end

    assign w_stage_dat[k] = r_dat;

    // Stages only load alongside a valid word, so the output stage holds
    // its last value between reads.
    if (k == CL - 1) begin : g_out
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_dat <= 16'd0;
        else if (w_vld_chain[k])  r_dat <= w_din;
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (w_vld_chain[k]) r_dat <= w_din;
      end
    end
  end

  assign w_dq_out = w_stage_dat[CL-1];

  assign bus.ddr4_dq_out = w_dq_out;
  assign bus.dq_valid    = r_vld[CL-1];
  assign bus.bank_open   = w_bank_open;
  assign bus.cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_ddr4_bank_responder.sv
// ----------------------------------------------------------------------------
// tb_ddr4_bank_responder
//
// Drives directed and random DDR4 commands into ddr4_bank_responder. A
// behavioural model (bank open flags, ACT edge numbers, a sparse memory)
// predicts read data, cmd_err pulses and bank_open; predictions are queued
// with the cycle they are due and a monitor compares them against the DUT.
// ----------------------------------------------------------------------------
module tb_ddr4_bank_responder;
  localparam int CL       = 3;
  localparam int TRCD     = 2;
  localparam int ROW_BITS = 2;
  localparam int COL_BITS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ddr4_bank_responder_if bus ();

  ddr4_bank_responder #(
    .CL(CL), .TRCD(TRCD), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_open [32];
  int          m_row  [32];
  int          m_act  [32];
  logic [15:0] m_mem  [int];

  typedef struct { int due; logic [15:0] d; bit known; } rd_t;
  typedef struct { int due; logic [31:0] v; } bo_t;
  rd_t rd_q [$];
  int  err_q[$];
  bo_t bo_q [$];

  function automatic logic [31:0] open_map();
    logic [31:0] m;
    for (int b = 0; b < 32; b++) m[b] = m_open[b];
    return m;
  endfunction

  function automatic int mkey(input int b, input int row, input int col);
    return (b * (1 << (ROW_BITS + COL_BITS))) + (row * (1 << COL_BITS)) + col;
  endfunction

  // Drives one command for the next rising edge and records what it must do.
  task automatic drive(input bit csn, input logic [2:0] rcw, input int bg, input int ba,
                       input logic [15:0] addr, input logic [15:0] dq);
    int  e, b, r, c, key;
    bit  legal;
    rd_t x;
    @(negedge clk);
    bus.ddr4_cs_n  = csn;
    bus.ddr4_ras_n = rcw[2];
    bus.ddr4_cas_n = rcw[1];
    bus.ddr4_we_n  = rcw[0];
    bus.ddr4_addr  = addr;
    bus.ddr4_ba    = 3'(ba);
    bus.ddr4_bg    = 2'(bg);
    bus.ddr4_dq_in = dq;
    if (!csn) begin
      e     = cyc + 1;
      b     = bg * 8 + ba;
      r     = int'(addr) % (1 << ROW_BITS);
      c     = int'(addr) % (1 << COL_BITS);
      legal = m_open[b] && (e >= m_act[b] + TRCD);
      key   = mkey(b, m_row[b], c);
      case (rcw)
        3'b011: begin
          if (m_open[b]) err_q.push_back(cyc + 1);
          else begin m_open[b] = 1'b1; m_row[b] = r; m_act[b] = e; end
        end
        3'b010: m_open[b] = 1'b0;
        3'b100: begin
          if (legal) m_mem[key] = dq;
          else       err_q.push_back(cyc + 1);
        end
        3'b101: begin
          if (legal) begin
            x.due   = cyc + CL;
            x.known = m_mem.exists(key);
            x.d     = x.known ? m_mem[key] : 16'h0;
            rd_q.push_back(x);
          end else err_q.push_back(cyc + 1);
        end
        default: ;
      endcase
    end
    bo_q.push_back('{cyc + 1, open_map()});
  endtask

  task automatic act(input int bg, input int ba, input int row);
    drive(1'b0, 3'b011, bg, ba, 16'(row), 16'h0);
  endtask
  task automatic wr(input int bg, input int ba, input int col, input logic [15:0] d);
    drive(1'b0, 3'b100, bg, ba, 16'(col), d);
  endtask
  task automatic rd(input int bg, input int ba, input int col);
    drive(1'b0, 3'b101, bg, ba, 16'(col), 16'h0);
  endtask
  task automatic pre(input int bg, input int ba);
    drive(1'b0, 3'b010, bg, ba, 16'h0, 16'h0);
  endtask
  task automatic nop(input int n);
    repeat (n) drive(1'b1, 3'b111, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ddr4_cs_n = 1'b1;
    for (int b = 0; b < 32; b++) m_open[b] = 1'b0;
    rd_q.delete();
    err_q.delete();
    bo_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [31:0] exp_bo     = 32'h0;
  logic [15:0] last_dq    = 16'h0;
  bit          last_known = 1'b1;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      chk("rst_dq_valid",  32'(bus.dq_valid),    32'h0);
      chk("rst_dq_out",    32'(bus.ddr4_dq_out), 32'h0);
      chk("rst_cmd_err",   32'(bus.cmd_err),     32'h0);
      chk("rst_bank_open", bus.bank_open,        32'h0);
      exp_bo     = 32'h0;
      last_dq    = 16'h0;
      last_known = 1'b1;
    end else begin
      while (bo_q.size() > 0 && bo_q[0].due <= cyc) exp_bo = bo_q.pop_front().v;
      chk("bank_open", bus.bank_open, exp_bo);

      if (err_q.size() > 0 && err_q[0] == cyc) begin
        void'(err_q.pop_front());
        chk("cmd_err", 32'(bus.cmd_err), 32'h1);
      end else begin
        chk("cmd_err", 32'(bus.cmd_err), 32'h0);
      end

      while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
        chk("rd_missed", 32'(rd_q[0].due), 32'(cyc));
        void'(rd_q.pop_front());
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        rd_t x;
        x = rd_q.pop_front();
        chk("dq_valid", 32'(bus.dq_valid), 32'h1);
        if (x.known) chk("rd_data", 32'(bus.ddr4_dq_out), 32'(x.d));
        last_dq    = x.d;
        last_known = x.known;
      end else begin
        chk("dq_valid_idle", 32'(bus.dq_valid), 32'h0);
        if (last_known) chk("dq_hold", 32'(bus.ddr4_dq_out), 32'(last_dq));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int sel, bg, ba;
    logic [2:0] rcw;
    bus.ddr4_cs_n  = 1'b1;
    bus.ddr4_ras_n = 1'b1;
    bus.ddr4_cas_n = 1'b1;
    bus.ddr4_we_n  = 1'b1;
    bus.ddr4_addr  = 16'h0;
    bus.ddr4_ba    = 3'h0;
    bus.ddr4_bg    = 2'h0;
    bus.ddr4_dq_in = 16'h0;

    // Reset while idle
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read on bank {1,2} = 10
    act(1, 2, 3); nop(TRCD - 1); wr(1, 2, 5, 16'hA5C3); rd(1, 2, 5); nop(CL + 1);

    // tRCD violation: the early write must not land
    act(2, 1, 1); nop(TRCD - 1); wr(2, 1, 7, 16'h1111); pre(2, 1);
    act(2, 1, 1); wr(2, 1, 7, 16'h2222); nop(TRCD); rd(2, 1, 7); nop(CL + 1); pre(2, 1);

    // ACT to an open bank keeps the original row
    act(3, 3, 2); nop(TRCD - 1); wr(3, 3, 0, 16'hBBBB); pre(3, 3);
    act(3, 3, 1); nop(TRCD - 1); wr(3, 3, 0, 16'hAAAA);
    act(3, 3, 2); nop(TRCD); rd(3, 3, 0); nop(CL + 1);

    // READ after PRE
    pre(3, 3); rd(3, 3, 0); nop(CL + 2);

    // Multi-bank streaming
    for (int g = 0; g < 4; g++) act(g, 0, g);
    nop(TRCD);
    for (int g = 0; g < 4; g++) wr(g, 0, 4, 16'h1000 + 16'(g));
    for (int g = 0; g < 4; g++) rd(g, 0, 4);
    nop(CL + 2);
    for (int g = 0; g < 4; g++) pre(g, 0);

    // Reset one cycle after a READ: the read is dropped, banks close
    rd(1, 2, 5); do_reset(); rd(1, 2, 5); nop(CL + 2);

    // Random traffic over a small set of banks
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 99);
      bg  = $urandom_range(0, 1);
      ba  = $urandom_range(0, 1);
      if (i == 200) do_reset();
      if (sel < 10) begin
        rcw = 3'($urandom_range(0, 7));
        drive(1'b1, rcw, bg, ba, 16'($urandom), 16'($urandom));
      end else if (sel < 25) drive(1'b0, 3'b011, bg, ba, 16'($urandom), 16'h0);
      else if (sel < 35)     drive(1'b0, 3'b010, bg, ba, 16'($urandom), 16'h0);
      else if (sel < 65)     drive(1'b0, 3'b100, bg, ba, 16'($urandom), 16'($urandom));
      else if (sel < 95)     drive(1'b0, 3'b101, bg, ba, 16'($urandom), 16'h0);
      else begin
        rcw = (sel[0]) ? 3'b001 : 3'b000;
        drive(1'b0, rcw, bg, ba, 16'($urandom), 16'h0);
      end
    end
    nop(CL + 4);
    chk("rd_q_drained",  32'(rd_q.size()),  32'h0);
    chk("err_q_drained", 32'(err_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
